// File: rtl/id_ex_register.sv
// ID->EX pipeline register of the 5-stage RISC-V core.
// Captures decoded control, operands and register addresses from ID on each
// rising edge. A NoOp or Flush request turns the captured instruction into a
// bubble, and a memory stall holds every register. Two saturating counters
// track bubbles inserted and valid instructions issued, for performance debug.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-low reset
//   MemStall_i             1 = hold all state (highest priority)
//   NoOp_i, Flush_i        either one = insert a bubble
//   <ctrl>_i / <ctrl>_o    RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc
//   <data>_i / <data>_o    PC, RS1data, RS2data, Imm, Funct, RS1addr, RS2addr, RDaddr
//   Valid_o                1 = EX holds a real instruction, 0 = bubble
//   BubbleCnt_o            saturating count of bubbles inserted
//   IssueCnt_o             saturating count of valid instructions issued
module id_ex_register #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemStall_i,
  input  logic             NoOp_i,
  input  logic             Flush_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic [XLEN-1:0]  PC_i,
  input  logic [XLEN-1:0]  RS1data_i,
  input  logic [XLEN-1:0]  RS2data_i,
  input  logic [XLEN-1:0]  Imm_i,
  input  logic [9:0]       Funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic [XLEN-1:0]  PC_o,
  output logic [XLEN-1:0]  RS1data_o,
  output logic [XLEN-1:0]  RS2data_o,
  output logic [XLEN-1:0]  Imm_o,
  output logic [9:0]       Funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             Valid_o,
  output logic [CNT_W-1:0] BubbleCnt_o,
  output logic [CNT_W-1:0] IssueCnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_BUBBLE  = 2'd1,
    MODE_CAPTURE = 2'd2
  } mode_e;

  mode_e mode_c;

  // Per-edge mode: stall beats bubble beats capture.
  always_comb begin
    mode_c = MODE_CAPTURE;
    if (MemStall_i) begin
      mode_c = MODE_HOLD;
    end else if (Flush_i || NoOp_i) begin
      mode_c = MODE_BUBBLE;
    end
  end

  // Control fields and RDaddr: zeroed on a bubble so nothing downstream matches it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUOp_o    <= 2'd0;
      ALUSrc_o   <= 1'b0;
      RDaddr_o   <= 5'd0;
      Valid_o    <= 1'b0;
    end else if (mode_c == MODE_BUBBLE) begin
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUOp_o    <= 2'd0;
      ALUSrc_o   <= 1'b0;
      RDaddr_o   <= 5'd0;
      Valid_o    <= 1'b0;
    end else if (mode_c == MODE_CAPTURE) begin
      RegWrite_o <= RegWrite_i;
      MemtoReg_o <= MemtoReg_i;
      MemRead_o  <= MemRead_i;
      MemWrite_o <= MemWrite_i;
      ALUOp_o    <= ALUOp_i;
      ALUSrc_o   <= ALUSrc_i;
      RDaddr_o   <= RDaddr_i;
      Valid_o    <= 1'b1;
    end
  end

  // Datapath fields: captured on bubble too, since their value is irrelevant then.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      PC_o      <= '0;
      RS1data_o <= '0;
      RS2data_o <= '0;
      Imm_o     <= '0;
      Funct_o   <= 10'd0;
      RS1addr_o <= 5'd0;
      RS2addr_o <= 5'd0;
    end else if (mode_c != MODE_HOLD) begin
      PC_o      <= PC_i;
      RS1data_o <= RS1data_i;
      RS2data_o <= RS2data_i;
      Imm_o     <= Imm_i;
      Funct_o   <= Funct_i;
      RS1addr_o <= RS1addr_i;
      RS2addr_o <= RS2addr_i;
    end
  end

  // Saturating performance counters; cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      BubbleCnt_o <= '0;
      IssueCnt_o  <= '0;
    end else begin
      if ((mode_c == MODE_BUBBLE) && (BubbleCnt_o != CNT_MAX)) begin
        BubbleCnt_o <= BubbleCnt_o + CNT_W'(1);
      end
      if ((mode_c == MODE_CAPTURE) && (IssueCnt_o != CNT_MAX)) begin
        IssueCnt_o <= IssueCnt_o + CNT_W'(1);
      end
    end
  end

endmodule
